// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Moore main-control FSM for a multicycle RV32I core, with a
//            memory-ready stall handshake and illegal-opcode detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               MemReady,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic               PCUpdate,
    output logic               Branch,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               Illegal,
    output logic               Retire,
    output logic [STATE_W-1:0] State
);

    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = STATE_W'(0),
        ST_DECODE   = STATE_W'(1),
        ST_MEMADR   = STATE_W'(2),
        ST_MEMREAD  = STATE_W'(3),
        ST_MEMWB    = STATE_W'(4),
        ST_MEMWRITE = STATE_W'(5),
        ST_EXECR    = STATE_W'(6),
        ST_ALUWB    = STATE_W'(7),
        ST_EXECI    = STATE_W'(8),
        ST_JAL      = STATE_W'(9),
        ST_BEQ      = STATE_W'(10),
        ST_ILLEGAL  = STATE_W'(11)
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign State = r_state;

    // Immediate format follows the opcode alone, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        w_next    = ST_FETCH;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        Illegal   = 1'b0;
        Retire    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCUpdate  = MemReady;
                w_next    = MemReady ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = ST_MEMADR;
                    c_OP_R:           w_next = ST_EXECR;
                    c_OP_I:           w_next = ST_EXECI;
                    c_OP_BEQ:         w_next = ST_BEQ;
                    c_OP_JAL:         w_next = ST_JAL;
                    default:          w_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == c_OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = MemReady ? ST_MEMWB : ST_MEMREAD;
            end
            ST_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            ST_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = MemReady;
                w_next   = MemReady ? ST_FETCH : ST_MEMWRITE;
            end
            ST_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = ST_ALUWB;
            end
            ST_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = ST_ALUWB;
            end
            ST_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                w_next   = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            ST_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                Retire  = 1'b1;
            end
            ST_ILLEGAL: begin
                Illegal = 1'b1;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase

        // Reset presents FETCH datapath selects with every strobe suppressed,
        // so an interrupted store or write-back has no effect this cycle.
        if (reset) begin
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b00;
            ResultSrc = 2'b10;
            PCUpdate  = 1'b0;
            Branch    = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            Illegal   = 1'b0;
            Retire    = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       MemReady;
    logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, Illegal, Retire;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
    logic [3:0] State;
    logic [15:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCUpdate, Branch, RegWrite, MemWrite, Illegal, Retire}
    localparam logic [15:0] E_FETCH_R1 = 16'b0_1_00_10_00_10_1_0_0_0_0_0;
    localparam logic [15:0] E_FETCH_R0 = 16'b0_0_00_10_00_10_0_0_0_0_0_0;
    localparam logic [15:0] E_RESET    = 16'b0_0_00_10_00_10_0_0_0_0_0_0;
    localparam logic [15:0] E_DECODE   = 16'b0_0_01_01_00_00_0_0_0_0_0_0;
    localparam logic [15:0] E_MEMADR   = 16'b0_0_10_01_00_00_0_0_0_0_0_0;
    localparam logic [15:0] E_MEMREAD  = 16'b1_0_00_00_00_00_0_0_0_0_0_0;
    localparam logic [15:0] E_MEMWB    = 16'b0_0_00_00_00_01_0_0_1_0_0_1;
    localparam logic [15:0] E_MEMWR_R0 = 16'b1_0_00_00_00_00_0_0_0_1_0_0;
    localparam logic [15:0] E_MEMWR_R1 = 16'b1_0_00_00_00_00_0_0_0_1_0_1;
    localparam logic [15:0] E_EXECR    = 16'b0_0_10_00_10_00_0_0_0_0_0_0;
    localparam logic [15:0] E_EXECI    = 16'b0_0_10_01_10_00_0_0_0_0_0_0;
    localparam logic [15:0] E_JAL      = 16'b0_0_01_10_00_00_1_0_0_0_0_0;
    localparam logic [15:0] E_ALUWB    = 16'b0_0_00_00_00_00_0_0_1_0_0_1;
    localparam logic [15:0] E_BEQ      = 16'b0_0_10_00_01_00_0_1_0_0_0_1;
    localparam logic [15:0] E_ILL      = 16'b0_0_00_00_00_00_0_0_0_0_1_0;

    assign outs = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                   PCUpdate, Branch, RegWrite, MemWrite, Illegal, Retire};

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .MemReady  (MemReady),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .PCUpdate  (PCUpdate),
        .Branch    (Branch),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .Illegal   (Illegal),
        .Retire    (Retire),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        MemReady = 1'b1;
        op       = 7'b0000011;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            n_checks++;
            if (State !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %0d expected 0", i, State);
            end
            n_checks++;
            if (outs !== E_RESET) begin
                n_fail++;
                $display("FAIL reset_outs[%0d]: got %b expected %b", i, outs, E_RESET);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs !== E_FETCH_R1 || State !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: got outs=%b st=%0d expected %b st=0", outs, State, E_FETCH_R1);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  st [5];
        logic [15:0] ex [5];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        ex = '{E_FETCH_R1, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            op = 7'b0000011; MemReady = 1'b1;
            #1;
            n_checks++;
            if (State !== st[i] || outs !== ex[i]) begin
                n_fail++;
                $display("FAIL lw[%0d]: got st=%0d outs=%b expected st=%0d outs=%b", i, State, outs, st[i], ex[i]);
            end
        end
        n_checks++;
        if (ImmSrc !== 2'b00) begin
            n_fail++;
            $display("FAIL lw_immsrc: got %b expected 00", ImmSrc);
        end
        tick(); #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL lw_return: got %0d expected 0", State);
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0]  st [7];
        logic [15:0] ex [7];
        logic        mr [7];
        st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        ex = '{E_FETCH_R1, E_DECODE, E_MEMADR, E_MEMWR_R0, E_MEMWR_R0, E_MEMWR_R0, E_MEMWR_R1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            op = 7'b0100011; MemReady = mr[i];
            #1;
            n_checks++;
            if (State !== st[i] || outs !== ex[i]) begin
                n_fail++;
                $display("FAIL sw[%0d]: got st=%0d outs=%b expected st=%0d outs=%b", i, State, outs, st[i], ex[i]);
            end
        end
        n_checks++;
        if (ImmSrc !== 2'b01) begin
            n_fail++;
            $display("FAIL sw_immsrc: got %b expected 01", ImmSrc);
        end
        tick(); #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL sw_return: got %0d expected 0", State);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  st [8];
        logic [15:0] ex [8];
        logic [6:0]  ops [8];
        st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8, 4'd7};
        ex  = '{E_FETCH_R1, E_DECODE, E_EXECR, E_ALUWB, E_FETCH_R1, E_DECODE, E_EXECI, E_ALUWB};
        ops = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            op = ops[i]; MemReady = 1'b1;
            #1;
            n_checks++;
            if (State !== st[i] || outs !== ex[i] || ImmSrc !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got st=%0d outs=%b imm=%b expected st=%0d outs=%b imm=00",
                         i, State, outs, ImmSrc, st[i], ex[i]);
            end
        end
        tick(); #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_return: got %0d expected 0", State);
        end
    endtask

    task automatic test_branch_jal();
        logic [3:0]  st [7];
        logic [15:0] ex [7];
        logic [6:0]  ops [7];
        logic [1:0]  imm [7];
        st  = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd1, 4'd9, 4'd7};
        ex  = '{E_FETCH_R1, E_DECODE, E_BEQ, E_FETCH_R1, E_DECODE, E_JAL, E_ALUWB};
        ops = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        imm = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            op = ops[i]; MemReady = 1'b1;
            #1;
            n_checks++;
            if (State !== st[i] || outs !== ex[i] || ImmSrc !== imm[i]) begin
                n_fail++;
                $display("FAIL brjal[%0d]: got st=%0d outs=%b imm=%b expected st=%0d outs=%b imm=%b",
                         i, State, outs, ImmSrc, st[i], ex[i], imm[i]);
            end
        end
        tick(); #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL brjal_return: got %0d expected 0", State);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [5];
        logic [15:0] ex [5];
        logic        mr [5];
        st = '{4'd0, 4'd0, 4'd1, 4'd11, 4'd0};
        ex = '{E_FETCH_R0, E_FETCH_R1, E_DECODE, E_ILL, E_FETCH_R1};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            op = 7'b1111111; MemReady = mr[i];
            #1;
            n_checks++;
            if (State !== st[i] || outs !== ex[i] || ImmSrc !== 2'b00) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got st=%0d outs=%b imm=%b expected st=%0d outs=%b imm=00",
                         i, State, outs, ImmSrc, st[i], ex[i]);
            end
        end
    endtask

    task automatic test_reset_midinstr();
        logic [3:0]  st [8];
        logic [15:0] ex [8];
        logic        mr [8];
        logic        rs [8];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0};
        ex = '{E_FETCH_R1, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_RESET, E_RESET, E_FETCH_R1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            op = 7'b0000011; MemReady = mr[i]; reset = rs[i];
            #1;
            n_checks++;
            if (State !== st[i] || outs !== ex[i]) begin
                n_fail++;
                $display("FAIL rst_mid[%0d]: got st=%0d outs=%b expected st=%0d outs=%b", i, State, outs, st[i], ex[i]);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        op       = 7'b0;
        MemReady = 1'b1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_back_to_back();
        test_branch_jal();
        test_illegal();
        test_reset_midinstr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle RV32I core.
- Sequences one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction, for lw, sw, R-type, I-type ALU, beq and jal.
- Sits beside the ALU decoder: drives ALUOp to it, and its PCUpdate/Branch outputs feed the PC-write logic.
- Adds a memory-ready stall handshake and illegal-opcode detection.

Parameters:
- STATE_W, 4, width of state register and debug State port.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  opcode field of the instruction register.
- MemReady  in  1  memory completes the current access this cycle.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  out  1  load instruction register (and OldPC).
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RegA.
- ALUSrcB  out  2  ALU B select: 00 RegB, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  to ALU decoder: 00 add, 01 sub/compare, 10 funct-decoded.
- ResultSrc  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
- ImmSrc  out  2  immediate format, combinational from op: I 00, S 01, B 10, J 11; 00 for other opcodes.
- PCUpdate  out  1  unconditional PC write.
- Branch  out  1  conditional PC write (ANDed with Zero externally).
- RegWrite  out  1  register file write.
- MemWrite  out  1  memory write strobe.
- Illegal  out  1  one-cycle pulse on unsupported opcode.
- Retire  out  1  one-cycle pulse in the final cycle of each legal instruction.
- State  out  STATE_W  current state encoding, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, ILLEGAL=11
  - Codes 12-15 behave as FETCH next cycle.
- Reset:
  - reset high at a rising edge → state = FETCH.
  - While reset is high, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, Illegal and Retire are forced 0.
  - The remaining outputs show FETCH values: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - Reset mid-instruction (e.g. in MEMWRITE) drops MemWrite in the same cycle; no partial write-back follows.
- Outputs decode from state only, except the MemReady gating listed below. Any output not listed for a state is 0.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - IRWrite = PCUpdate = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → ILLEGAL
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00. Stays while MemReady=0; goes to MEMWB when MemReady=1.
- MEMWB: ResultSrc 01, RegWrite 1, Retire 1 → FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1 held for the whole state.
  - MemReady=1 → Retire 1, next FETCH. Otherwise stays.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10 → ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10 → ALUWB.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00 (target to PC), PCUpdate 1 → ALUWB (PC+4 to rd).
- ALUWB: ResultSrc 00, RegWrite 1, Retire 1 → FETCH.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1, Retire 1 → FETCH.
- ILLEGAL: Illegal 1 for one cycle, no register or memory writes, Retire 0 → FETCH.
- Cycle counts with MemReady tied to 1:
  - lw 5
  - sw 4, R-type 4, I-type 4, jal 4
  - beq 3
  - illegal 3
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- MemReady is ignored in every other state.

Test Plan:
- Reset held 2 cycles then released, MemReady=1 → State=0 during reset with all write enables 0; first cycle after release IRWrite=1, PCUpdate=1, ALUSrcB=10.
- op=0000011, MemReady=1 → States 0,1,2,3,4; RegWrite=1 and ResultSrc=01 only in state 4; Retire once; back to 0 on cycle 6.
- op=0100011, MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles with AdrSrc=1; Retire on the 4th; no RegWrite at any point.
- op=0110011 then 0010011 back-to-back → paths 0,1,6,7 and 0,1,8,7; ALUOp=10 in EXECR/EXECI; ALUSrcB 00 vs 01; RegWrite exactly once per instruction.
- op=1100011 then op=1101111 → beq: Branch=1, ALUOp=01 in state 10, 3 cycles. jal: PCUpdate=1 in state 9, then RegWrite in state 7; ImmSrc=10 and 11 respectively.
- op=1111111 → ILLEGAL: Illegal=1 for exactly one cycle, Retire=0, no writes, returns to FETCH. Also reset asserted during MEMREAD with MemReady=0 → State=0 next cycle, RegWrite never asserted.
